// File: rtl/axi4_write_master.sv
// AXI4 single-beat write initiator: one command in, one AW/W/B exchange out,
// one completion (normal or timed-out) back. Only one transaction in flight.
module axi4_write_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_data,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   output logic                busy,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP,
      S_REPORT
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   data_reg, data_next;
   logic [STRB_W-1:0]   strb_reg, strb_next;
   logic                awvalid_reg, awvalid_next;
   logic                wvalid_reg, wvalid_next;
   logic                bready_reg, bready_next;
   logic                aw_done_reg, aw_done_next;
   logic                w_done_reg, w_done_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                rsp_valid_reg, rsp_valid_next;
   logic [1:0]          rsp_resp_reg, rsp_resp_next;
   logic                rsp_timeout_reg, rsp_timeout_next;

   logic                timeout_hit;
   logic [CNT_W-1:0]    cnt_inc;

   // TIMEOUT=0 leaves the counter parked at zero and never fires.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);
   assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      data_next        = data_reg;
      strb_next        = strb_reg;
      awvalid_next     = awvalid_reg;
      wvalid_next      = wvalid_reg;
      bready_next      = bready_reg;
      aw_done_next     = aw_done_reg;
      w_done_next      = w_done_reg;
      cnt_next         = cnt_reg;
      rsp_valid_next   = rsp_valid_reg;
      rsp_resp_next    = rsp_resp_reg;
      rsp_timeout_next = rsp_timeout_reg;

      case (state_reg)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_next    = cmd_addr;
               data_next    = cmd_data;
               strb_next    = cmd_strb;
               awvalid_next = 1'b1;
               wvalid_next  = 1'b1;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               cnt_next     = '0;
               state_next   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_next = cnt_inc;
            if (awvalid_reg && m_awready) begin
               awvalid_next = 1'b0;
               aw_done_next = 1'b1;
            end
            if (wvalid_reg && m_wready) begin
               wvalid_next = 1'b0;
               w_done_next = 1'b1;
            end
            // A final AW/W handshake landing on the timeout cycle still times out.
            if (timeout_hit) begin
               awvalid_next     = 1'b0;
               wvalid_next      = 1'b0;
               rsp_resp_next    = 2'b10;
               rsp_timeout_next = 1'b1;
               rsp_valid_next   = 1'b1;
               state_next       = S_REPORT;
            end else if (aw_done_next && w_done_next) begin
               bready_next = 1'b1;
               state_next  = S_RESP;
            end
         end
         S_RESP: begin
            cnt_next = cnt_inc;
            if (m_bvalid) begin
               rsp_resp_next    = m_bresp;
               rsp_timeout_next = 1'b0;
               rsp_valid_next   = 1'b1;
               bready_next      = 1'b0;
               state_next       = S_REPORT;
            end else if (timeout_hit) begin
               bready_next      = 1'b0;
               rsp_resp_next    = 2'b10;
               rsp_timeout_next = 1'b1;
               rsp_valid_next   = 1'b1;
               state_next       = S_REPORT;
            end
         end
         S_REPORT: begin
            if (rsp_ready) begin
               rsp_valid_next = 1'b0;
               state_next     = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= S_IDLE;
         addr_reg        <= '0;
         data_reg        <= '0;
         strb_reg        <= '0;
         awvalid_reg     <= 1'b0;
         wvalid_reg      <= 1'b0;
         bready_reg      <= 1'b0;
         aw_done_reg     <= 1'b0;
         w_done_reg      <= 1'b0;
         cnt_reg         <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_resp_reg    <= 2'b00;
         rsp_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         data_reg        <= data_next;
         strb_reg        <= strb_next;
         awvalid_reg     <= awvalid_next;
         wvalid_reg      <= wvalid_next;
         bready_reg      <= bready_next;
         aw_done_reg     <= aw_done_next;
         w_done_reg      <= w_done_next;
         cnt_reg         <= cnt_next;
         rsp_valid_reg   <= rsp_valid_next;
         rsp_resp_reg    <= rsp_resp_next;
         rsp_timeout_reg <= rsp_timeout_next;
      end
   end

   assign cmd_ready   = (state_reg == S_IDLE);
   assign busy        = (state_reg != S_IDLE);
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_resp    = rsp_resp_reg;
   assign rsp_timeout = rsp_timeout_reg;
   assign m_awaddr    = addr_reg;
   assign m_awvalid   = awvalid_reg;
   assign m_wdata     = data_reg;
   assign m_wstrb     = strb_reg;
   assign m_wvalid    = wvalid_reg;
   assign m_bready    = bready_reg;

endmodule

// File: tb/tb_axi4_write_master.sv
// Bench for axi4_write_master: a delay-programmable AXI slave plus a latency /
// outcome model derived from handshake timing rules, over directed and random cases.
module tb_axi4_write_master;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic [3:0]  cmd_strb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic        busy;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready = 1'b0;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready = 1'b0;
   logic [1:0]  m_bresp = 2'b00;
   logic        m_bvalid = 1'b0;
   logic        m_bready;

   int n_cmp = 0;
   int n_fail = 0;
   int n_txn = 0;

   axi4_write_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   always #5 clk = ~clk;

   // Slave behaviour knobs, set by the transaction driver.
   int         da_g = 0, dw_g = 0, db_g = 0;
   bit         spur_g = 1'b0;
   logic [1:0] bresp_g = 2'b00;

   // Slave bookkeeping, written only by the slave process.
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int          naw_g = 0, nw_g = 0, unstable_g = 0;
   bit          aw_seen = 1'b0, w_seen = 1'b0;
   logic [31:0] aw_first = '0, w_first = '0;
   logic [3:0]  ws_first = '0;
   logic [31:0] awaddr_g = '0, wdata_g = '0;
   logic [3:0]  wstrb_g = '0;

   // READY is raised after the programmed number of VALID cycles; the handshake
   // then happens on the following rising edge.
   always @(negedge clk) begin
      if (m_awvalid) begin
         m_awready <= (aw_cnt >= da_g);
         aw_cnt    <= aw_cnt + 1;
         if (aw_cnt >= da_g) begin
            naw_g    <= naw_g + 1;
            awaddr_g <= m_awaddr;
         end
         if (aw_seen && m_awaddr !== aw_first) unstable_g <= unstable_g + 1;
         aw_seen  <= 1'b1;
         aw_first <= m_awaddr;
      end else begin
         m_awready <= 1'b0;
         aw_cnt    <= 0;
         aw_seen   <= 1'b0;
      end
      if (m_wvalid) begin
         m_wready <= (w_cnt >= dw_g);
         w_cnt    <= w_cnt + 1;
         if (w_cnt >= dw_g) begin
            nw_g    <= nw_g + 1;
            wdata_g <= m_wdata;
            wstrb_g <= m_wstrb;
         end
         if (w_seen && (m_wdata !== w_first || m_wstrb !== ws_first)) unstable_g <= unstable_g + 1;
         w_seen   <= 1'b1;
         w_first  <= m_wdata;
         ws_first <= m_wstrb;
      end else begin
         m_wready <= 1'b0;
         w_cnt    <= 0;
         w_seen   <= 1'b0;
      end
      if (m_bready) begin
         m_bvalid <= (b_cnt >= db_g);
         m_bresp  <= bresp_g;
         b_cnt    <= b_cnt + 1;
      end else begin
         m_bvalid <= spur_g && busy;
         m_bresp  <= 2'b11;
         b_cnt    <= 0;
      end
   end

   // Reference: AW completes in issue cycle da+1, W in dw+1, B arrives db cycles
   // into the response phase; the watchdog fires in issue cycle T and loses
   // only to a B handshake in that same cycle.
   task automatic model(input int da, input int dw, input int db,
                        output int l, output bit tmo, output int naw, output int nw);
      int m;
      m   = ((da > dw) ? da : dw) + 1;
      tmo = (m >= T) || (m + 1 + db > T);
      l   = tmo ? T : m + 1 + db;
      naw = (da < T) ? 1 : 0;
      nw  = (dw < T) ? 1 : 0;
   endtask

   task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int da, input int dw, input int db, input int hold,
                         input bit spur, input logic [1:0] br,
                         output int lat, output logic [1:0] resp, output logic tmo,
                         output int naw, output int nw,
                         output logic [31:0] ga, output logic [31:0] gd, output logic [3:0] gs,
                         output bit got_rsp, output bit hold_ok, output bit post_ok,
                         output bit stab_ok, output bit quiet_ok);
      int nb, nwb, ub;
      da_g = da; dw_g = dw; db_g = db; spur_g = spur; bresp_g = br;
      nb = naw_g; nwb = nw_g; ub = unstable_g;
      cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      got_rsp = 1'b0; lat = -1; hold_ok = 1'b1; post_ok = 1'b0; quiet_ok = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k - 1;
            got_rsp = 1'b1;
            break;
         end
      end
      resp = rsp_resp;
      tmo  = rsp_timeout;
      quiet_ok = !m_awvalid && !m_wvalid && !m_bready;
      if (got_rsp) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_resp !== resp || cmd_ready) hold_ok = 1'b0;
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         post_ok = !rsp_valid && cmd_ready;
         rsp_ready = 1'b0;
      end
      naw = naw_g - nb; nw = nw_g - nwb;
      stab_ok = (unstable_g == ub);
      ga = awaddr_g; gd = wdata_g; gs = wstrb_g;
      n_txn++;
      $display("txn %0d addr=%h data=%h strb=%h da=%0d dw=%0d db=%0d -> lat=%0d resp=%b tmo=%b",
               n_txn, a, d, s, da, dw, db, lat, resp, tmo);
   endtask

   // Shared locals for the scenario tasks (only one runs at a time).
   int          lat, naw, nw, el, enaw, enw;
   logic [1:0]  resp;
   logic        tmo;
   bit          etmo, got, hok, pok, sok, qok;
   logic [31:0] ga, gd;
   logic [3:0]  gs;

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if ({cmd_ready, busy, m_awvalid, m_wvalid, m_bready, rsp_valid, rsp_timeout, rsp_resp} !== 9'b1_0000_0000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want %b",
                  {cmd_ready, busy, m_awvalid, m_wvalid, m_bready, rsp_valid, rsp_timeout, rsp_resp}, 9'b1_0000_0000);
      end
      n_cmp++;
      if ({m_awaddr, m_wdata, m_wstrb} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0", {m_awaddr, m_wdata, m_wstrb});
      end
   endtask

   task automatic test_ready_slave();
      do_txn(32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 1'b0, 2'b00,
             lat, resp, tmo, naw, nw, ga, gd, gs, got, hok, pok, sok, qok);
      model(0, 0, 1, el, etmo, enaw, enw);
      n_cmp++;
      if (lat != el) begin n_fail++; $display("FAIL ready_lat: got %0d want %0d", lat, el); end
      n_cmp++;
      if ({resp, tmo} !== 3'b000) begin n_fail++; $display("FAIL ready_resp: got %b want 000", {resp, tmo}); end
      n_cmp++;
      if ({ga, gd, gs} !== {32'h100, 32'hDEADBEEF, 4'hF}) begin
         n_fail++; $display("FAIL ready_payload: got %h %h %h want 100 deadbeef f", ga, gd, gs);
      end
      n_cmp++;
      if (!pok) begin n_fail++; $display("FAIL ready_rsp_handshake: got %0d want 1", pok); end
   endtask

   task automatic test_aw_delay();
      do_txn(32'h1234_5670, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 0, 1'b1, 2'b00,
             lat, resp, tmo, naw, nw, ga, gd, gs, got, hok, pok, sok, qok);
      model(3, 0, 0, el, etmo, enaw, enw);
      n_cmp++;
      if (lat != el) begin n_fail++; $display("FAIL awdly_lat: got %0d want %0d", lat, el); end
      n_cmp++;
      if (!sok) begin n_fail++; $display("FAIL awdly_stable: got %0d want 1", sok); end
      n_cmp++;
      if ({resp, tmo, naw, nw} !== {2'b00, 1'b0, 32'd1, 32'd1}) begin
         n_fail++; $display("FAIL awdly_resp: got resp=%b tmo=%b naw=%0d nw=%0d want 00 0 1 1", resp, tmo, naw, nw);
      end
   endtask

   task automatic test_bresp_hold();
      do_txn(32'h0000_0040, 32'h5555_AAAA, 4'hC, 1, 2, 2, 4, 1'b1, 2'b10,
             lat, resp, tmo, naw, nw, ga, gd, gs, got, hok, pok, sok, qok);
      n_cmp++;
      if ({resp, tmo} !== 3'b100) begin n_fail++; $display("FAIL hold_resp: got %b want 100", {resp, tmo}); end
      n_cmp++;
      if (!hok) begin n_fail++; $display("FAIL hold_stable: got %0d want 1", hok); end
      n_cmp++;
      if (!pok) begin n_fail++; $display("FAIL hold_release: got %0d want 1", pok); end
   endtask

   task automatic test_timeout();
      int cases [5][3] = '{'{0, 0, 1000}, '{0, 0, 6}, '{0, 0, 7}, '{7, 0, 0}, '{9, 2, 0}};
      for (int c = 0; c < 5; c++) begin
         do_txn(32'h3000 + 32'(c), 32'hA5A5_0000 + 32'(c), 4'h5, cases[c][0], cases[c][1], cases[c][2],
                0, 1'b0, 2'b01, lat, resp, tmo, naw, nw, ga, gd, gs, got, hok, pok, sok, qok);
         model(cases[c][0], cases[c][1], cases[c][2], el, etmo, enaw, enw);
         n_cmp++;
         if (lat != el || tmo !== etmo) begin
            n_fail++; $display("FAIL tmo_outcome[%0d]: got lat=%0d tmo=%b want lat=%0d tmo=%b", c, lat, tmo, el, etmo);
         end
         n_cmp++;
         if (resp !== (etmo ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL tmo_resp[%0d]: got %b want %b", c, resp, etmo ? 2'b10 : 2'b01);
         end
         n_cmp++;
         if (naw != enaw || nw != enw || !qok) begin
            n_fail++; $display("FAIL tmo_chan[%0d]: got naw=%0d nw=%0d quiet=%0d want %0d %0d 1", c, naw, nw, qok, enaw, enw);
         end
      end
      n_cmp++;
      if (el != 8) begin n_fail++; $display("FAIL tmo_model_last: got %0d want 8", el); end
   endtask

   task automatic test_reset_mid();
      bit stale;
      da_g = 5; dw_g = 5; db_g = 0; spur_g = 1'b0;
      cmd_addr = 32'h0000_0DEA; cmd_data = 32'h1111_1111; cmd_strb = 4'hF; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if ({m_awvalid, m_wvalid, m_bready, rsp_valid, busy, cmd_ready} !== 6'b000001) begin
         n_fail++;
         $display("FAIL midrst_abort: got %b want 000001", {m_awvalid, m_wvalid, m_bready, rsp_valid, busy, cmd_ready});
      end
      stale = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid || busy) stale = 1'b1;
      end
      n_cmp++;
      if (stale) begin n_fail++; $display("FAIL midrst_stale: got 1 want 0"); end
      do_txn(32'h200, 32'h0BAD_CAFE, 4'h9, 1, 0, 0, 0, 1'b0, 2'b00,
             lat, resp, tmo, naw, nw, ga, gd, gs, got, hok, pok, sok, qok);
      model(1, 0, 0, el, etmo, enaw, enw);
      n_cmp++;
      if (ga !== 32'h200 || gd !== 32'h0BAD_CAFE || lat != el || {resp, tmo} !== 3'b000) begin
         n_fail++; $display("FAIL midrst_clean: got addr=%h data=%h lat=%0d resp=%b want 200 0badcafe %0d 000",
                            ga, gd, lat, {resp, tmo}, el);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 4; c++) begin
         logic [31:0] a, d;
         a = 32'h8000 + 32'(c) * 32'h10;
         d = $urandom;
         do_txn(a, d, 4'(c + 1), 0, 2, 0, 0, 1'b0, 2'b00,
                lat, resp, tmo, naw, nw, ga, gd, gs, got, hok, pok, sok, qok);
         model(0, 2, 0, el, etmo, enaw, enw);
         n_cmp++;
         if (ga !== a || gd !== d || gs !== 4'(c + 1) || naw != 1 || nw != 1) begin
            n_fail++; $display("FAIL b2b_order[%0d]: got %h %h %h n=%0d/%0d want %h %h %h 1/1",
                               c, ga, gd, gs, naw, nw, a, d, 4'(c + 1));
         end
         n_cmp++;
         if (lat != el || !pok) begin
            n_fail++; $display("FAIL b2b_timing[%0d]: got lat=%0d post=%0d want %0d 1", c, lat, pok, el);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 24; c++) begin
         logic [31:0] a, d;
         logic [3:0]  s;
         logic [1:0]  br;
         int da, dw, db, hold;
         a = $urandom; d = $urandom; s = 4'($urandom_range(15, 0)); br = 2'($urandom_range(3, 0));
         da = $urandom_range(8, 0); dw = $urandom_range(8, 0); db = $urandom_range(6, 0);
         hold = $urandom_range(3, 0);
         do_txn(a, d, s, da, dw, db, hold, 1'($urandom_range(1, 0)), br,
                lat, resp, tmo, naw, nw, ga, gd, gs, got, hok, pok, sok, qok);
         model(da, dw, db, el, etmo, enaw, enw);
         n_cmp++;
         if (lat != el || tmo !== etmo || resp !== (etmo ? 2'b10 : br)) begin
            n_fail++; $display("FAIL rand_rsp[%0d]: got lat=%0d tmo=%b resp=%b want %0d %b %b",
                               c, lat, tmo, resp, el, etmo, etmo ? 2'b10 : br);
         end
         n_cmp++;
         if (naw != enaw || nw != enw || (enaw == 1 && ga !== a) || (enw == 1 && (gd !== d || gs !== s))) begin
            n_fail++; $display("FAIL rand_chan[%0d]: got n=%0d/%0d %h %h %h want n=%0d/%0d %h %h %h",
                               c, naw, nw, ga, gd, gs, enaw, enw, a, d, s);
         end
         n_cmp++;
         if (!hok || !pok || !sok || !qok) begin
            n_fail++; $display("FAIL rand_proto[%0d]: got hold=%0d post=%0d stable=%0d quiet=%0d want 1111",
                               c, hok, pok, sok, qok);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ready_slave();
      test_aw_delay();
      test_bresp_hold();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
